func2_cursor_ctrl: RTL

//  Consumer of the function-2 button instruction bus {East,West,North,South}: turns button

---
 rtl/func2_cursor_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/func2_cursor_ctrl.sv
// Cursor controller for the function-2 button bus: per-press step, hold-to-repeat, wrap at every edge.
// Move appears two edges after a button input is captured; the position is held whenever FUNC_ID is not active.
module func2_cursor_ctrl #(
  parameter int GRID_W       = 8,
  parameter int GRID_H       = 6,
  parameter int X_BITS       = 3,
  parameter int Y_BITS       = 3,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int FUNC_ID      = 1
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [1:0]        func_index,
  input  logic [3:0]        func2_instruction,
  output logic [X_BITS-1:0] cursor_x,
  output logic [Y_BITS-1:0] cursor_y,
  output logic              move_strobe,
  output logic              active
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]  RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [X_BITS-1:0] X_MAX      = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_MAX      = Y_BITS'(GRID_H - 1);
  localparam logic [1:0]        FUNC_SEL   = 2'(FUNC_ID);

  localparam logic [3:0] DIR_E = 4'b1000;
  localparam logic [3:0] DIR_W = 4'b0100;
  localparam logic [3:0] DIR_N = 4'b0010;
  localparam logic [3:0] DIR_S = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_REPEAT
  } state_t;

  logic [1:0]       r_func_s1, r_func_s2;
  logic [3:0]       r_instr_s1, r_instr_s2;
  state_t           r_state;
  logic [3:0]       r_dir_lat;
  logic [CNT_W-1:0] r_cnt;

  logic             w_en;
  logic             w_onehot;
  logic [3:0]       w_dir;
  logic [X_BITS-1:0] w_next_x;
  logic [Y_BITS-1:0] w_next_y;

  assign w_en     = (r_func_s2 == FUNC_SEL);
  // Chords and releases both decode to NONE (all zero).
  assign w_onehot = (r_instr_s2 != 4'd0) && ((r_instr_s2 & (r_instr_s2 - 4'd1)) == 4'd0);
  assign w_dir    = w_onehot ? r_instr_s2 : 4'd0;

  always_comb begin
    w_next_x = cursor_x;
    w_next_y = cursor_y;
    case (w_dir)
      DIR_E:   w_next_x = (cursor_x == X_MAX) ? '0 : cursor_x + X_BITS'(1);
      DIR_W:   w_next_x = (cursor_x == '0) ? X_MAX : cursor_x - X_BITS'(1);
      DIR_N:   w_next_y = (cursor_y == '0) ? Y_MAX : cursor_y - Y_BITS'(1);
      DIR_S:   w_next_y = (cursor_y == Y_MAX) ? '0 : cursor_y + Y_BITS'(1);
      default: ;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_func_s1   <= '0;
      r_func_s2   <= '0;
      r_instr_s1  <= '0;
      r_instr_s2  <= '0;
      r_state     <= S_IDLE;
      r_dir_lat   <= '0;
      r_cnt       <= '0;
      cursor_x    <= '0;
      cursor_y    <= '0;
      move_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      r_func_s1   <= func_index;
      r_func_s2   <= r_func_s1;
      r_instr_s1  <= func2_instruction;
      r_instr_s2  <= r_instr_s1;
      active      <= w_en;
      move_strobe <= 1'b0;
      if (!w_en) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_dir != 4'd0) begin
              cursor_x    <= w_next_x;
              cursor_y    <= w_next_y;
              move_strobe <= 1'b1;
              r_dir_lat   <= w_dir;
              r_cnt       <= '0;
              r_state     <= S_FIRST;
            end
          end
          S_FIRST: begin
            if (w_dir != r_dir_lat) begin
              r_state <= S_IDLE;
            end else if (r_cnt == DELAY_LAST) begin
              cursor_x    <= w_next_x;
              cursor_y    <= w_next_y;
              move_strobe <= 1'b1;
              r_cnt       <= '0;
              r_state     <= S_REPEAT;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_REPEAT: begin
            // A changed direction passes through IDLE so the new one starts with a fresh delay.
            if (w_dir != r_dir_lat) begin
              r_state <= S_IDLE;
            end else if (r_cnt == RATE_LAST) begin
              cursor_x    <= w_next_x;
              cursor_y    <= w_next_y;
              move_strobe <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
